// File: rtl/sector_bram_writer.sv
// Captures one sector of bytes from a valid/ready stream into BRAM, one byte per cycle, registered write port.
// Optional XOR checksum of captured bytes is enabled with the SECTOR_CHECKSUM_EN macro.
module sector_bram_writer #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(SECTOR_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              done_q, done_d;
  logic              hs;
  logic              start_acc;
  logic [ADDR_W:0]   count_inc;

  // abort gates ready combinationally so a byte offered alongside abort is never taken
  assign in_ready  = (state_q == WRITE) && !abort;
  assign hs        = in_valid && in_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          ptr_d   = base_addr;
          count_d = '0;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          din_d   = in_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_inc;
          if (count_inc == LAST_COUNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

`ifdef SECTOR_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_acc) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign checksum         = 8'h00;
`endif

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign byte_count = count_q;

endmodule
